// File: rtl/gate_sweep_pkg.sv
// Shared types, defaults and the golden AND-reduction
// used by the gate sweep tester.
package gate_sweep_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int SETTLE_DEF = 2;
    localparam int N_MAX      = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_e;

    // Only the low n bits of v take part in the reduction.
    function automatic logic golden_and(
        input logic [N_MAX-1:0] v,
        input int               n
    );
        logic r;
        r = 1'b1;
        for (int i = 0; i < N_MAX; i++) begin
            if (i < n) r = r & v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter; expired_o is high once the loaded
// settle interval has elapsed.
module sweep_settle_timer
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic expired_o
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_tester.sv
// Exhaustive stimulus/check sweep for a small AND-type gate.
// Optional first-failure capture: GATE_SWEEP_FIRST_FAIL_EN.
module gate_sweep_tester
    import gate_sweep_pkg::*;
#(
    parameter int N_IN          = N_IN_DEF,
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_f,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] vec_idx
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    ,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
`endif
);

    if (SETTLE_CYCLES < 1) begin : g_settle_chk
        $error("SETTLE_CYCLES must be >= 1");
    end
    if (N_IN < 2 || N_IN > N_MAX) begin : g_nin_chk
        $error("N_IN must be in 2..8");
    end

    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            load;
    logic            expired;
    logic            accept;
    logic            mismatch;
    logic            is_last;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic [N_IN-1:0] ff_vec_q, ff_vec_d;
    logic            ff_valid_q, ff_valid_d;
`endif

    sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .expired_o(expired)
    );

    // start is only honoured when no sweep is running
    assign accept   = start && (state_q == IDLE || state_q == DONE);
    assign mismatch = dut_f != golden_and(N_MAX'(vec_q), N_IN);
    assign is_last  = (vec_q == VEC_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETTLE;
            SETTLE:  if (expired) state_d = CHECK;
            CHECK:   state_d = is_last ? DONE : SETTLE;
            DONE:    if (accept) state_d = SETTLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_d  = vec_q;
        err_d  = err_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        load   = 1'b0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
`endif
        if (accept) begin
            vec_d  = '0;
            err_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
            pass_d = 1'b0;
            load   = 1'b1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            ff_vec_d   = '0;
            ff_valid_d = 1'b0;
`endif
        end else if (state_q == CHECK) begin
            if (mismatch) begin
                err_d = err_q + ERR_ONE;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                if (!ff_valid_q) begin
                    ff_vec_d   = vec_q;
                    ff_valid_d = 1'b1;
                end
`endif
            end
            if (is_last) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_d == '0);
            end else begin
                vec_d = vec_q + VEC_ONE;
                load  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_q  <= '0;
            err_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
`endif
        end else begin
            vec_q  <= vec_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
`endif
        end
    end

    assign dut_in    = vec_q;
    assign vec_idx   = vec_q;
    assign err_count = err_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;
`endif

endmodule

// File: tb/tb_gate_sweep_tester.sv
// Scoreboard bench for gate_sweep_tester driving a
// table-defined fake gate with random fault patterns.
module tb_gate_sweep_tester;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int NV = 1 << N;
    localparam int VC = S + 1;
    localparam int LAT = NV * VC;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N-1:0]   dut_in;
    logic           dut_f;
    logic           busy;
    logic           done;
    logic           pass;
    logic [N:0]     err_count;
    logic [N-1:0]   vec_idx;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic [N-1:0]   first_fail_vec;
    logic           first_fail_valid;
`endif

    logic [NV-1:0]  tt_cur;

    typedef struct {
        logic [NV-1:0] tt;
        int            err;
        int            ffv;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  t0     = 0;
    int  rel;
    bit  track  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fake gate: output for each input vector comes from the truth table.
    assign dut_f = tt_cur[dut_in];

    gate_sweep_tester #(
        .N_IN(N),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dut_in   (dut_in),
        .dut_f    (dut_f),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .vec_idx  (vec_idx)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        ,
        .first_fail_vec  (first_fail_vec),
        .first_fail_valid(first_fail_valid)
`endif
    );

    // A 4-input AND is 1 only for the all-ones vector.
    function automatic int model_err(logic [NV-1:0] tt, int nv);
        int e = 0;
        for (int v = 0; v < nv; v++) begin
            if (tt[v] != (v == NV - 1)) e++;
        end
        return e;
    endfunction

    function automatic int model_ff(logic [NV-1:0] tt, int nv);
        for (int v = 0; v < nv; v++) begin
            if (tt[v] != (v == NV - 1)) return v;
        end
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(string name);
        chk({name, " dut_in"}, dut_in, 0);
        chk({name, " vec_idx"}, vec_idx, 0);
        chk({name, " err"}, err_count, 0);
        chk({name, " busy"}, busy, 0);
        chk({name, " done"}, done, 0);
        chk({name, " pass"}, pass, 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk({name, " ff_vec"}, first_fail_vec, 0);
        chk({name, " ff_valid"}, first_fail_valid, 0);
`endif
    endtask

    // Monitor: checks every cycle of a tracked sweep against the model.
    always @(negedge clk) begin
        if (track && cyc >= t0) begin
            rel = cyc - t0;
            if (rel == 0) begin
                if (q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    cur = q.pop_front();
                end
            end
            chk("vec", dut_in, (rel < LAT) ? rel / VC : NV - 1);
            chk("vec_idx", vec_idx, dut_in);
            chk("busy", busy, rel < LAT);
            chk("done", done, rel == LAT);
            chk("err_run", err_count, model_err(cur.tt, rel / VC));
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            begin
                int f;
                f = model_ff(cur.tt, rel / VC);
                chk("ff_valid", first_fail_valid, f >= 0);
                chk("ff_vec", first_fail_vec, (f >= 0) ? f : 0);
            end
`endif
            if (rel < LAT) begin
                chk("pass_busy", pass, 0);
            end else begin
                chk("final_err", err_count, cur.err);
                chk("pass", pass, cur.err == 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                chk("final_ff", first_fail_vec,
                    (cur.ffv >= 0) ? cur.ffv : 0);
`endif
                track = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_sweep(logic [NV-1:0] tt, bit noise, int abort_at);
        exp_t e;
        bit   aborted = 1'b0;
        e.tt  = tt;
        e.err = model_err(tt, NV);
        e.ffv = model_ff(tt, NV);
        tt_cur = tt;
        q.push_back(e);
        t0    = cyc + 1;
        track = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < LAT + 40; i++) begin
            if (!track) break;
            if (abort_at >= 0 && vec_idx == abort_at[N-1:0]) begin
                reset   = 1'b1;
                track   = 1'b0;
                q.delete();
                aborted = 1'b1;
                break;
            end
            start = noise && (vec_idx == 5);
            @(negedge clk);
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            reset = 1'b0;
            chk_idle("rst_mid");
        end else if (track) begin
            chk("timeout", 1, 0);
            track = 1'b0;
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        tt_cur = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle("reset");

        // start and reset together: reset wins
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        chk_idle("start_rst_idle");

        run_sweep(16'h8000, 1'b0, -1);
        run_sweep(16'h0000, 1'b0, -1);
        run_sweep(16'hFFFF, 1'b0, -1);
        run_sweep(16'h8000, 1'b1, -1);
        @(negedge clk);
        run_sweep(16'h8000, 1'b0, 7);
        run_sweep(16'h8000, 1'b0, -1);
        run_sweep(16'h0F0F, 1'b0, -1);
        run_sweep(16'h8000, 1'b0, -1);

        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        chk_idle("start_rst_done");

        for (int k = 0; k < 8; k++) begin
            logic [NV-1:0] tt;
            tt = NV'($urandom);
            if ($urandom_range(0, 2) == 0) tt = 16'h8000;
            run_sweep(tt, 1'($urandom), -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
